piso_stream: RTL
================

Name: piso_stream

Overview:
- Parametrised parallel-in/serial-out shift engine with a valid/ready load handshake.
- A one-word holding buffer allows back-to-back frames with no idle gap.
- A shift_en strobe sets the bit rate, so the serial clock can be divided down.
- Sits between a word-producing block and a serial line driver (UART-style TX, SPI MOSI, test serialiser).

Parameters:
- WIDTH, 8, bits per frame (>=2).
- MSB_FIRST, 1, 1 = pin[WIDTH-1] is sent first; 0 = pin[0] is sent first.
- IDLE_LEVEL, 0, value driven on sout while no frame is shifting.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- pin  in  WIDTH  parallel word to serialise.
- in_valid  in  1  pin is valid.
- in_ready  out  1  block can accept a word this cycle.
- shift_en  in  1  bit-rate strobe; the shift register advances only on edges where this is 1.
- sout  out  1  serial data.
- sout_valid  out  1  sout carries frame data.
- frame_start  out  1  high while the first bit of a frame is on sout.
- done  out  1  one-cycle pulse after the last bit of a frame is consumed with no follow-on frame.
- busy  out  1  state==SHIFT or hold_full.

Behaviour:
- Clocking/reset: one clock, clk. rst is synchronous and active-high.
- Storage: shreg[WIDTH], bitcnt (clog2 WIDTH bits), hold_reg[WIDTH], hold_full, state {IDLE, SHIFT}.
- Reset values: state=IDLE, shreg=0, hold_reg=0, hold_full=0, bitcnt=0. Outputs: sout=IDLE_LEVEL, sout_valid=0, frame_start=0, done=0, busy=0. in_ready=0 while rst is high, 1 on the first cycle after.
- Reset mid-frame: the frame is aborted and the held word is discarded. No done pulse.
- Handshake:
  - in_ready = !hold_full && !rst (combinational from registers).
  - A word is accepted on an edge where in_valid && in_ready. At that edge: hold_reg<=pin, hold_full<=1.
  - in_valid while in_ready=0 is ignored; the producer must hold the word.
- IDLE:
  - sout=IDLE_LEVEL, sout_valid=0.
  - If hold_full, the next edge moves hold_reg into shreg, clears hold_full, sets bitcnt=0 and enters SHIFT. shift_en is not required for this transfer.
  - Latency: accept at edge E0, load at E1, first bit on sout in the cycle after E1.
- SHIFT:
  - sout = shreg[WIDTH-1] if MSB_FIRST, else shreg[0]. sout_valid=1.
  - frame_start=1 while bitcnt==0.
  - On an edge with shift_en=1 and bitcnt<WIDTH-1: shift toward the output end, filling with 0; bitcnt+1.
  - On an edge with shift_en=1 and bitcnt==WIDTH-1:
    - If hold_full: reload shreg from hold_reg, clear hold_full, bitcnt=0, stay in SHIFT. No gap between frames and no done pulse.
    - Else: go to IDLE; done=1 for exactly the following cycle.
  - shift_en=0 holds all shift state. shift_en in IDLE is ignored.
- Simultaneous accept and transfer (IDLE load or end-of-frame reload on the same edge as an accept): impossible by construction, because in_ready=0 whenever hold_full=1. After the transfer, in_ready rises the next cycle.
- A word accepted during SHIFT waits in hold_reg. At most one frame shifting plus one held.
- All outputs except in_ready are registered or decoded from registered state only. No combinational path from pin or in_valid to sout.

Test Plan (WIDTH=4, IDLE_LEVEL=0 unless stated):
1. Reset, then MSB_FIRST=1, pin=4'b1010, in_valid for one cycle, shift_en=1 constant -> sout=1,0,1,0 on 4 consecutive cycles starting 2 cycles after accept. frame_start on the first bit only. done pulse in the cycle after the last bit. busy drops with done.
2. MSB_FIRST=0, pin=4'b1101 -> sout=1,0,1,1 (LSB first). sout_valid high for exactly 4 cycles.
3. Back-to-back: pin=4'b1011, then 4'b0110 presented as soon as in_ready rises -> 8 contiguous sout_valid cycles, 1,0,1,1,0,1,1,0. frame_start twice. Single done pulse at the end. in_ready low while hold_full.
4. shift_en high every 3rd cycle, pin=4'b1001 -> each bit held 3 cycles. Sequence 1,0,0,1. Holding pin/in_valid with in_ready=0 causes no extra accepts.
5. rst asserted after the 2nd bit of frame 4'b1100, with 4'b0011 held in the buffer -> the next cycle shows sout=IDLE_LEVEL, sout_valid=0, busy=0, no done. The held word is never transmitted.
6. IDLE_LEVEL=1, no input -> sout stays 1. in_valid=1 while rst=1 -> not accepted (in_ready=0).

Source files
------------

// File: rtl/piso_stream_if.sv
// Load/serial-side signal bundle for piso_stream.
// The producer side drives the word and the bit-rate strobe; the shifter drives everything else.
interface piso_stream_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] pin;
  logic             in_valid;
  logic             in_ready;
  logic             shift_en;
  logic             sout;
  logic             sout_valid;
  logic             frame_start;
  logic             done;
  logic             busy;

  modport master (
    output pin, in_valid, shift_en,
    input  in_ready, sout, sout_valid, frame_start, done, busy
  );

  modport slave (
    input  pin, in_valid, shift_en,
    output in_ready, sout, sout_valid, frame_start, done, busy
  );
endinterface

// File: rtl/piso_stream.sv
// Parallel-in/serial-out shifter with a one-word holding buffer and a bit-rate strobe.
// Frames run back to back when a word is already held at the end of the current frame.
module piso_stream #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input logic           clk,
  input logic           rst,
  piso_stream_if.slave  bus
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  typedef enum logic {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [CntW-1:0]  bitcnt_q, bitcnt_d;
  logic             done_q, done_d;

  logic             in_ready;
  logic             sout_s, sout_valid_s, frame_start_s, busy_s;

  assign in_ready = ~hold_full_q & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      shreg_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      bitcnt_q    <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      bitcnt_q    <= bitcnt_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    bitcnt_d    = bitcnt_q;
    done_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Load from the buffer does not wait for shift_en.
        if (hold_full_q) begin
          state_d     = StShift;
          shreg_d     = hold_q;
          hold_full_d = 1'b0;
          bitcnt_d    = '0;
        end
      end
      StShift: begin
        if (bus.shift_en) begin
          if (bitcnt_q != LastBit) begin
            if (MSB_FIRST) shreg_d = shreg_q << 1;
            else           shreg_d = shreg_q >> 1;
            bitcnt_d = bitcnt_q + 1'b1;
          end else if (hold_full_q) begin
            shreg_d     = hold_q;
            hold_full_d = 1'b0;
            bitcnt_d    = '0;
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Accept never coincides with a buffer transfer: in_ready is low while hold_full_q is set.
    if (bus.in_valid && in_ready) begin
      hold_d      = bus.pin;
      hold_full_d = 1'b1;
    end
  end

  always_comb begin
    sout_s        = IDLE_LEVEL;
    sout_valid_s  = 1'b0;
    frame_start_s = 1'b0;
    if (state_q == StShift) begin
      sout_s        = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
      sout_valid_s  = 1'b1;
      frame_start_s = (bitcnt_q == '0);
    end
    busy_s = (state_q == StShift) | hold_full_q;
  end

  assign bus.in_ready    = in_ready;
  assign bus.sout        = sout_s;
  assign bus.sout_valid  = sout_valid_s;
  assign bus.frame_start = frame_start_s;
  assign bus.done        = done_q;
  assign bus.busy        = busy_s;

endmodule
